// File: rtl/ddr4_sref_sequencer_if.sv
// ddr4_sref_sequencer_if: software command/status and per-channel MIG handshake bundle
interface ddr4_sref_sequencer_if #(
    parameter int NUM_CH = 3
);
    logic              cmd_enter;
    logic              cmd_exit;
    logic [NUM_CH-1:0] ch_mask;
    logic [NUM_CH-1:0] sref_ack;
    logic [NUM_CH-1:0] calib_complete;
    logic [NUM_CH-1:0] sref_req;
    logic [NUM_CH-1:0] mem_init_skip;
    logic [NUM_CH-1:0] xsdb_select;
    logic [NUM_CH-1:0] restore_complete;
    logic              pr_safe;
    logic              busy;
    logic              done;
    logic              err;
    logic [1:0]        err_code;
    logic [2:0]        state;

    modport master (
        output cmd_enter, cmd_exit, ch_mask, sref_ack, calib_complete,
        input  sref_req, mem_init_skip, xsdb_select, restore_complete,
        input  pr_safe, busy, done, err, err_code, state
    );

    modport slave (
        input  cmd_enter, cmd_exit, ch_mask, sref_ack, calib_complete,
        output sref_req, mem_init_skip, xsdb_select, restore_complete,
        output pr_safe, busy, done, err, err_code, state
    );
endinterface

// File: rtl/ddr4_sref_sequencer.sv
// ddr4_sref_sequencer: DDR4 self-refresh save/restore sequencing around partial reconfiguration
module ddr4_sref_sequencer #(
    parameter int NUM_CH         = 3,
    parameter int ACK_TIMEOUT    = 1048576,
    parameter int RESTORE_CYCLES = 64,
    parameter int CAL_TIMEOUT    = 4194304
) (
    input logic                  CLK_IN_125M,
    input logic                  AXI_RESET_N,
    ddr4_sref_sequencer_if.slave bus
);
    localparam int CW = $clog2(ACK_TIMEOUT > CAL_TIMEOUT ? ACK_TIMEOUT : CAL_TIMEOUT);
    localparam logic [CW-1:0] ACK_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] RST_LAST = CW'(RESTORE_CYCLES - 1);
    localparam logic [CW-1:0] CAL_LAST = CW'(CAL_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ENTER_WAIT = 3'd1,
        IN_SREF    = 3'd2,
        RESTORE    = 3'd3,
        CAL_WAIT   = 3'd4,
        ERROR      = 3'd5
    } state_t;

    state_t            state_q;
    logic [NUM_CH-1:0] mask_q;
    logic [CW-1:0]     cnt_q;
    logic [NUM_CH-1:0] sref_req_q;
    logic [NUM_CH-1:0] skip_q;
    logic [NUM_CH-1:0] xsdb_q;
    logic [NUM_CH-1:0] rc_q;
    logic              pr_safe_q;
    logic              done_q;
    logic              err_q;
    logic [1:0]        err_code_q;
    logic [NUM_CH-1:0] ack_meta_q;
    logic [NUM_CH-1:0] ack_sync_q;
    logic [NUM_CH-1:0] cal_meta_q;
    logic [NUM_CH-1:0] cal_sync_q;

    // Two-flop synchronisers for the MIG status inputs, which are asynchronous to this clock
    always_ff @(posedge CLK_IN_125M) begin
        if (!AXI_RESET_N) begin
            ack_meta_q <= '0;
            ack_sync_q <= '0;
            cal_meta_q <= '0;
            cal_sync_q <= '0;
        end else begin
            ack_meta_q <= bus.sref_ack;
            ack_sync_q <= ack_meta_q;
            cal_meta_q <= bus.calib_complete;
            cal_sync_q <= cal_meta_q;
        end
    end

    // Sequencer FSM; the counter saturates and restarts from zero on every state change
    always_ff @(posedge CLK_IN_125M) begin
        if (!AXI_RESET_N) begin
            state_q    <= IDLE;
            mask_q     <= '0;
            cnt_q      <= '0;
            sref_req_q <= '0;
            skip_q     <= '0;
            xsdb_q     <= '0;
            rc_q       <= '0;
            pr_safe_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            done_q <= 1'b0;
            cnt_q  <= (&cnt_q) ? cnt_q : cnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_enter && |bus.ch_mask) begin
                        state_q    <= ENTER_WAIT;
                        mask_q     <= bus.ch_mask;
                        sref_req_q <= bus.ch_mask;
                        cnt_q      <= '0;
                    end
                end
                ENTER_WAIT: begin
                    if ((ack_sync_q & mask_q) == mask_q) begin
                        state_q   <= IN_SREF;
                        done_q    <= 1'b1;
                        pr_safe_q <= 1'b1;
                        cnt_q     <= '0;
                    end else if (cnt_q == ACK_LAST) begin
                        state_q    <= ERROR;
                        err_q      <= 1'b1;
                        err_code_q <= 2'b01;
                        sref_req_q <= '0;
                        cnt_q      <= '0;
                    end
                end
                IN_SREF: begin
                    if ((ack_sync_q & mask_q) != mask_q) begin
                        state_q    <= ERROR;
                        err_q      <= 1'b1;
                        err_code_q <= 2'b10;
                        sref_req_q <= '0;
                        pr_safe_q  <= 1'b0;
                        cnt_q      <= '0;
                    end else if (bus.cmd_exit) begin
                        state_q    <= RESTORE;
                        sref_req_q <= '0;
                        skip_q     <= mask_q;
                        xsdb_q     <= mask_q;
                        pr_safe_q  <= 1'b0;
                        cnt_q      <= '0;
                    end
                end
                RESTORE: begin
                    if (cnt_q == RST_LAST) begin
                        state_q <= CAL_WAIT;
                        rc_q    <= mask_q;
                        xsdb_q  <= '0;
                        cnt_q   <= '0;
                    end
                end
                CAL_WAIT: begin
                    if ((cal_sync_q & mask_q) == mask_q) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                        skip_q  <= '0;
                        rc_q    <= '0;
                        mask_q  <= '0;
                        cnt_q   <= '0;
                    end else if (cnt_q == CAL_LAST) begin
                        state_q    <= ERROR;
                        err_q      <= 1'b1;
                        err_code_q <= 2'b11;
                        rc_q       <= '0;
                        cnt_q      <= '0;
                    end
                end
                ERROR: begin
                    if (bus.cmd_exit) begin
                        state_q    <= IDLE;
                        err_q      <= 1'b0;
                        err_code_q <= 2'b00;
                        mask_q     <= '0;
                        skip_q     <= '0;
                        cnt_q      <= '0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign bus.sref_req         = sref_req_q;
    assign bus.mem_init_skip    = skip_q;
    assign bus.xsdb_select      = xsdb_q;
    assign bus.restore_complete = rc_q;
    assign bus.pr_safe          = pr_safe_q;
    assign bus.done             = done_q;
    assign bus.err              = err_q;
    assign bus.err_code         = err_code_q;
    assign bus.state            = state_q;
    assign bus.busy             = (state_q != IDLE) && (state_q != IN_SREF);
endmodule

// File: tb/tb_ddr4_sref_sequencer.sv
// tb_ddr4_sref_sequencer: scoreboard bench for the self-refresh sequencer
module tb_ddr4_sref_sequencer;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    typedef struct {
        string       tag;
        logic [20:0] exp;
    } exp_t;
    exp_t sb[$];

    ddr4_sref_sequencer_if #(.NUM_CH(3)) bus ();

    ddr4_sref_sequencer #(
        .NUM_CH(3),
        .ACK_TIMEOUT(32),
        .RESTORE_CYCLES(8),
        .CAL_TIMEOUT(16)
    ) dut (
        .CLK_IN_125M(clk),
        .AXI_RESET_N(rst_n),
        .bus(bus)
    );

    always #4 clk = ~clk;

    logic [20:0] obs;
    assign obs = {bus.state, bus.err_code, bus.err, bus.done, bus.busy, bus.pr_safe,
                  bus.restore_complete, bus.xsdb_select, bus.mem_init_skip, bus.sref_req};

    task automatic chk(input string tag, input logic [20:0] got, input logic [20:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] ov(input logic [2:0] st, input logic [1:0] ec,
                                       input logic er, input logic dn, input logic ps,
                                       input logic [2:0] rc, input logic [2:0] xs,
                                       input logic [2:0] sk, input logic [2:0] sr);
        ov = {st, ec, er, dn, (st != 3'd0 && st != 3'd2), ps, rc, xs, sk, sr};
    endfunction

    task automatic push(input string tag, input logic [20:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic pop_cmp();
        exp_t e;
        e = sb.pop_front();
        chk(e.tag, obs, e.exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    localparam logic [20:0] ZERO = 21'd0;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1);
    end

    initial begin
        bus.cmd_enter      = 1'b0;
        bus.cmd_exit       = 1'b0;
        bus.ch_mask        = 3'b000;
        bus.sref_ack       = 3'b000;
        bus.calib_complete = 3'b000;
        step(3);
        push("reset", ZERO); pop_cmp();
        rst_n = 1'b1;
        step(1);
        // enter with empty mask is ignored
        bus.cmd_enter = 1'b1; bus.ch_mask = 3'b000;
        push("enter_mask0", ZERO); step(1); pop_cmp();
        // enter and exit together: enter wins; ack[1] is unmasked and must not count
        bus.cmd_enter = 1'b1; bus.cmd_exit = 1'b1; bus.ch_mask = 3'b101; bus.sref_ack = 3'b010;
        push("enter_wins", ov(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b101));
        step(1); pop_cmp();
        bus.cmd_enter = 1'b0; bus.cmd_exit = 1'b0;
        push("ack_wait", ov(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b101));
        step(9); pop_cmp();
        bus.sref_ack = 3'b111;
        push("ack_sync", ov(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b101));
        step(2); pop_cmp();
        push("in_sref", ov(3'd2, 2'd0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 3'b101));
        step(1); pop_cmp();
        push("done_clr", ov(3'd2, 2'd0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'b101));
        step(1); pop_cmp();
        // one-cycle drop of ack[2]
        bus.sref_ack = 3'b011;
        step(1);
        bus.sref_ack = 3'b111;
        push("loss_sync", ov(3'd2, 2'd0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'b101));
        step(1); pop_cmp();
        push("ack_lost", ov(3'd5, 2'b10, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000));
        step(1); pop_cmp();
        bus.cmd_exit = 1'b1; bus.sref_ack = 3'b101;
        push("lost_clr", ZERO); step(1); pop_cmp();
        bus.cmd_exit = 1'b0;
        push("idle_hold", ZERO); step(2); pop_cmp();
        // ack timeout with ack[1] never rising
        bus.cmd_enter = 1'b1; bus.ch_mask = 3'b111;
        step(1);
        bus.cmd_enter = 1'b0;
        push("to_wait", ov(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b111));
        step(31); pop_cmp();
        push("ack_to", ov(3'd5, 2'b01, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000));
        step(1); pop_cmp();
        bus.cmd_enter = 1'b1;
        push("err_enter_ign", ov(3'd5, 2'b01, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000));
        step(1); pop_cmp();
        bus.cmd_enter = 1'b0; bus.cmd_exit = 1'b1;
        push("to_clr", ZERO); step(1); pop_cmp();
        bus.cmd_exit = 1'b0;
        // full exit with mask 011
        bus.cmd_enter = 1'b1; bus.ch_mask = 3'b011; bus.sref_ack = 3'b011;
        push("enter2", ov(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b011));
        step(1); pop_cmp();
        bus.cmd_enter = 1'b0;
        push("in_sref2", ov(3'd2, 2'd0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 3'b011));
        step(2); pop_cmp();
        bus.cmd_enter = 1'b1; bus.ch_mask = 3'b111;
        push("sref_enter_ign", ov(3'd2, 2'd0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'b011));
        step(1); pop_cmp();
        bus.cmd_enter = 1'b0; bus.cmd_exit = 1'b1;
        push("restore", ov(3'd3, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b011, 3'b011, 3'b000));
        step(1); pop_cmp();
        bus.cmd_exit = 1'b0;
        push("restore_hold", ov(3'd3, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b011, 3'b011, 3'b000));
        step(7); pop_cmp();
        push("cal_wait", ov(3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 3'b011, 3'b000, 3'b011, 3'b000));
        step(1); pop_cmp();
        bus.calib_complete = 3'b011;
        push("cal_sync", ov(3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 3'b011, 3'b000, 3'b011, 3'b000));
        step(2); pop_cmp();
        push("exit_done", ov(3'd0, 2'd0, 1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000));
        step(1); pop_cmp();
        push("exit_idle", ZERO); step(1); pop_cmp();
        // calibration timeout with only calib[0]
        bus.calib_complete = 3'b001; bus.cmd_enter = 1'b1; bus.ch_mask = 3'b011;
        push("enter3", ov(3'd1, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b011));
        step(1); pop_cmp();
        bus.cmd_enter = 1'b0;
        push("in_sref3", ov(3'd2, 2'd0, 1'b0, 1'b1, 1'b1, 3'b000, 3'b000, 3'b000, 3'b011));
        step(1); pop_cmp();
        bus.cmd_exit = 1'b1;
        step(1);
        bus.cmd_exit = 1'b0;
        push("cal_wait2", ov(3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 3'b011, 3'b000, 3'b011, 3'b000));
        step(8); pop_cmp();
        push("cal_hold", ov(3'd4, 2'd0, 1'b0, 1'b0, 1'b0, 3'b011, 3'b000, 3'b011, 3'b000));
        step(15); pop_cmp();
        push("cal_to", ov(3'd5, 2'b11, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b011, 3'b000));
        step(1); pop_cmp();
        bus.cmd_exit = 1'b1;
        push("cal_clr", ZERO); step(1); pop_cmp();
        bus.cmd_exit = 1'b0;
        // reset asserted mid-RESTORE
        bus.cmd_enter = 1'b1;
        step(1);
        bus.cmd_enter = 1'b0;
        step(1);
        bus.cmd_exit = 1'b1;
        step(1);
        bus.cmd_exit = 1'b0;
        push("restore3", ov(3'd3, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b011, 3'b011, 3'b000));
        step(3); pop_cmp();
        rst_n = 1'b0;
        push("rst_mid", ZERO); step(1); pop_cmp();
        rst_n = 1'b1;
        push("rst_rel", ZERO); step(1); pop_cmp();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/ddr4_sref_sequencer.md
Name: ddr4_sref_sequencer

Overview:
- Sequences the DDR4 self-refresh save/restore handshake for up to three MIG channels (c0/c2/c3) around partial reconfiguration of the dynamic region.
- Sits in the static shell. Software issues enter/exit commands; the block drives each channel's app_sref_req, app_mem_init_skip, app_xsdb_select and app_restore_complete, and tracks app_sref_ack and init_calib_complete.
- Reports PR-safe status, a completion pulse and timeout errors.

Parameters:
- NUM_CH, 3, number of DDR4 channels sequenced (bit 0=c0, 1=c2, 2=c3).
- ACK_TIMEOUT, 1048576, max cycles from sref_req assertion to all masked acks.
- RESTORE_CYCLES, 64, cycles xsdb_select is held before restore_complete is asserted.
- CAL_TIMEOUT, 4194304, max cycles from restore_complete to all masked calib_complete.

Ports:
- CLK_IN_125M  in  1  block clock; all logic on rising edge.
- AXI_RESET_N  in  1  reset, synchronous and active-low.
- cmd_enter  in  1  one-cycle pulse: enter self-refresh on ch_mask.
- cmd_exit  in  1  one-cycle pulse: restore and exit self-refresh; also clears ERROR.
- ch_mask  in  NUM_CH  channel select, sampled with cmd_enter.
- sref_ack  in  NUM_CH  app_sref_ack per channel, async to CLK_IN_125M.
- calib_complete  in  NUM_CH  init_calib_complete per channel, async.
- sref_req  out  NUM_CH  app_sref_req per channel.
- mem_init_skip  out  NUM_CH  app_mem_init_skip per channel.
- xsdb_select  out  NUM_CH  app_xsdb_select per channel.
- restore_complete  out  NUM_CH  app_restore_complete per channel.
- pr_safe  out  1  all masked channels in self-refresh.
- busy  out  1  state is not IDLE and not IN_SREF.
- done  out  1  one-cycle pulse on successful enter or exit completion.
- err  out  1  sticky error flag.
- err_code  out  2  00 none, 01 ack timeout, 10 ack lost in IN_SREF, 11 calib timeout.
- state  out  3  current FSM state encoding.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, and the latched mask and counters are 0.
- Synchronisers: sref_ack and calib_complete each pass through 2-flop synchronisers. All decisions use the synchronised values.
- FSM encoding: IDLE=0, ENTER_WAIT=1, IN_SREF=2, RESTORE=3, CAL_WAIT=4, ERROR=5.
- IDLE:
  - cmd_enter with ch_mask!=0: latch mask, go to ENTER_WAIT. sref_req=mask is registered one cycle after the cmd_enter sample.
  - cmd_enter with ch_mask==0: ignored, no state change.
  - cmd_exit: ignored.
  - cmd_enter and cmd_exit in the same cycle: enter wins.
- ENTER_WAIT:
  - Counter runs from 0.
  - (sync_ack & mask)==mask: go to IN_SREF, pulse done, set pr_safe next cycle.
  - Counter reaches ACK_TIMEOUT-1 first: go to ERROR, err_code=01.
  - Commands are ignored.
- IN_SREF:
  - sref_req held, pr_safe=1.
  - Any masked ack drops to 0: ERROR, err_code=10.
  - cmd_exit: go to RESTORE. sref_req=0, mem_init_skip=mask, xsdb_select=mask, pr_safe=0.
  - cmd_enter: ignored.
- RESTORE:
  - Hold RESTORE_CYCLES cycles.
  - Then set restore_complete=mask, xsdb_select=0, and go to CAL_WAIT.
- CAL_WAIT:
  - Counter runs from 0.
  - (sync_calib & mask)==mask: pulse done, clear mem_init_skip and restore_complete, clear mask, go to IDLE.
  - Counter reaches CAL_TIMEOUT-1 first: ERROR, err_code=11.
- ERROR:
  - sref_req, xsdb_select and restore_complete forced to 0. mem_init_skip held. err=1.
  - cmd_exit: clear err, err_code and mask, go to IDLE.
  - cmd_enter: ignored.
- Counter rules: counter width is clog2(max(ACK_TIMEOUT, CAL_TIMEOUT)). It saturates and never wraps, and clears on every state change.
- Reset mid-sequence: all outputs drop to 0 the next edge, including releasing sref_req. Software must treat DRAM contents as lost.
- Unmasked channels: their outputs stay 0 throughout.

Test Plan:
- Enter, ack delay 10 cycles: mask=3'b101, cmd_enter, ack[0] and ack[2] rise 10 cycles later -> sref_req=101 at +1; pr_safe=1 and done pulse at ack+2 sync cycles +1; ack[1] ignored.
- Ack timeout (ACK_TIMEOUT=32): mask=3'b111, ack[1] never rises -> ERROR at cycle 32; err_code=01; sref_req=000; cmd_exit returns to IDLE with err=0.
- Full exit (RESTORE_CYCLES=8): from IN_SREF mask=011, cmd_exit -> mem_init_skip=011 and xsdb_select=011 for 8 cycles; then restore_complete=011; calib on both -> done, all outputs 0, state=0.
- Calib timeout (CAL_TIMEOUT=16): only calib[0] rises -> ERROR with err_code=11.
- Ack loss: in IN_SREF, drop ack[2] for one synchronised cycle -> ERROR, err_code=10.
- Edge cases:
  - cmd_enter with mask=0 -> stays IDLE.
  - cmd_enter and cmd_exit simultaneous in IDLE -> enter taken.
  - AXI_RESET_N low during RESTORE -> all outputs 0 the next cycle, state=0.
